gpio_bank: RTL

//  Parametrised memory-mapped GPIO: N_CH channels of DW-bit input and output ports on one WE/A/WD/RD bus.

---
 rtl/gpio_bank_if.sv | 15 +
 rtl/gpio_bank.sv | 116 +++++++++++
 2 files changed

// File: rtl/gpio_bank_if.sv
// Data-memory bus slice seen by the GPIO bank: write strobe, address, write data, read data.
interface gpio_bank_if #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned DW   = 32
) ();
  localparam int unsigned AW = $clog2(N_CH) + 3;

  logic          WE;
  logic [AW-1:0] A;
  logic [DW-1:0] WD;
  logic [DW-1:0] RD;

  modport master (output WE, output A, output WD, input RD);
  modport slave  (input WE, input A, input WD, output RD);
endinterface

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: synchronised inputs, set/clear/toggle outputs, sticky rising-edge
// interrupt status with per-bit enables folded into a single Irq line.
module gpio_bank #(
  parameter int unsigned    N_CH    = 2,
  parameter int unsigned    DW      = 32,
  parameter int unsigned    SYNC    = 2,
  parameter logic [DW-1:0]  OUT_RST = '0
) (
  input  logic               Clk,
  input  logic               Rst,
  gpio_bank_if.slave         bus,
  input  logic [N_CH*DW-1:0] gpI,
  output logic [N_CH*DW-1:0] gpO,
  output logic               Irq
);
  localparam int unsigned CW = $clog2(SYNC + 2);

  typedef enum logic [2:0] {
    RegIn   = 3'd0,
    RegOut  = 3'd1,
    RegSet  = 3'd2,
    RegClr  = 3'd3,
    RegTgl  = 3'd4,
    RegIen  = 3'd5,
    RegStat = 3'd6,
    RegRsvd = 3'd7
  } regAddrT;

  logic [DW-1:0] syncQ [N_CH][SYNC];
  logic [DW-1:0] prevQ [N_CH];
  logic [DW-1:0] outQ  [N_CH];
  logic [DW-1:0] outD  [N_CH];
  logic [DW-1:0] ienQ  [N_CH];
  logic [DW-1:0] ienD  [N_CH];
  logic [DW-1:0] statQ [N_CH];
  logic [DW-1:0] statD [N_CH];
  logic [DW-1:0] rise  [N_CH];
  logic [CW-1:0] cntQ;
  logic          armedQ;
  int unsigned   chIdx;
  regAddrT       regSel;

  // Out-of-range channel indices simply never match a channel below.
  assign chIdx  = 32'(bus.A >> 3);
  assign regSel = regAddrT'(bus.A[2:0]);

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      rise[c]  = armedQ ? (syncQ[c][SYNC-1] & ~prevQ[c]) : '0;
      outD[c]  = outQ[c];
      ienD[c]  = ienQ[c];
      statD[c] = statQ[c] | rise[c];
      if (bus.WE && chIdx == c) begin
        case (regSel)
          RegOut:  outD[c]  = bus.WD;
          RegSet:  outD[c]  = outQ[c] | bus.WD;
          RegClr:  outD[c]  = outQ[c] & ~bus.WD;
          RegTgl:  outD[c]  = outQ[c] ^ bus.WD;
          RegIen:  ienD[c]  = bus.WD;
          // A new rise in the same cycle beats the clear.
          RegStat: statD[c] = (statQ[c] & ~bus.WD) | rise[c];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        for (int unsigned s = 0; s < SYNC; s++) syncQ[c][s] <= '0;
        prevQ[c] <= '0;
        outQ[c]  <= OUT_RST;
        ienQ[c]  <= '0;
        statQ[c] <= '0;
      end
      cntQ   <= '0;
      armedQ <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        syncQ[c][0] <= gpI[c*DW +: DW];
        for (int unsigned s = 1; s < SYNC; s++) syncQ[c][s] <= syncQ[c][s-1];
        prevQ[c] <= syncQ[c][SYNC-1];
        outQ[c]  <= outD[c];
        ienQ[c]  <= ienD[c];
        statQ[c] <= statD[c];
      end
      // Arm only once prev holds a real sample, so pins high out of reset never look like rises.
      if (!armedQ) cntQ <= cntQ + 1'b1;
      armedQ <= armedQ | (cntQ == CW'(SYNC));
    end
  end

  always_comb begin
    bus.RD = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (chIdx == c) begin
        case (regSel)
          RegIn:   bus.RD = syncQ[c][SYNC-1];
          RegOut:  bus.RD = outQ[c];
          RegIen:  bus.RD = ienQ[c];
          RegStat: bus.RD = statQ[c];
          default: bus.RD = '0;
        endcase
      end
    end
  end

  always_comb begin
    Irq = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      gpO[c*DW +: DW] = outQ[c];
      Irq = Irq | (|(statQ[c] & ienQ[c]));
    end
  end
endmodule
